// File: rtl/pdh_capture_pkg.sv
// rtl/pdh_capture_pkg.sv - shared types and helpers for the PDH capture front end
// Contents:
//   trig_mode_t : trigger mode as programmed in the register file
//   fe_state_t  : front-end FSM state, encoding visible through the status register
//   N_CH        : number of packed PDH channels
//   ch_lsb()    : bit offset of a channel inside the packed sample word
package pdh_capture_pkg;

    localparam int N_CH = 4;

    typedef enum logic [1:0] {
        IMMEDIATE = 2'd0,
        RISING    = 2'd1,
        FALLING   = 2'd2,
        EITHER    = 2'd3
    } trig_mode_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HOLDOFF   = 3'd1,
        WAIT_TRIG = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4,
        DONE      = 3'd5
    } fe_state_t;

    // Channel n occupies bits [n*ch_w +: ch_w] of the packed word.
    function automatic int unsigned ch_lsb(input logic [1:0] ch, input int unsigned ch_w);
        return ch_w * 32'(ch);
    endfunction

endpackage

// File: rtl/posedge_detector.sv
// rtl/posedge_detector.sv - single-flop rising-edge detector
// Ports:
//   pdh_clk, rst_i : clock, async active-high reset
//   sig_i          : level input
//   edge_o         : high in the cycle where sig_i is 1 and was 0 on the previous edge
module posedge_detector (
    input  logic pdh_clk,
    input  logic rst_i,
    input  logic sig_i,
    output logic edge_o
);

    logic sig_q;

    always_ff @(posedge pdh_clk or posedge rst_i) begin
        if (rst_i) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign edge_o = sig_i & ~sig_q;

endmodule

// File: rtl/trig_crossing_detector.sv
// rtl/trig_crossing_detector.sv - sample history and signed level-crossing relations
// Ports:
//   pdh_clk, rst_i : clock, async active-high reset
//   sample_i       : selected channel sample (signed)
//   level_i        : latched trigger threshold (signed)
//   rising_o       : prev < level and cur >= level
//   falling_o      : prev > level and cur <= level
//   prev_valid_o   : prev holds a real sample (second cycle after reset onward)
module trig_crossing_detector #(
    parameter int CH_W = 16
) (
    input  logic                   pdh_clk,
    input  logic                   rst_i,
    input  logic signed [CH_W-1:0] sample_i,
    input  logic signed [CH_W-1:0] level_i,
    output logic                   rising_o,
    output logic                   falling_o,
    output logic                   prev_valid_o
);

    logic signed [CH_W-1:0] cur_q;
    logic signed [CH_W-1:0] prev_q;
    logic                   cur_valid_q;
    logic                   prev_valid_q;

    always_ff @(posedge pdh_clk or posedge rst_i) begin
        if (rst_i) begin
            cur_q        <= '0;
            prev_q       <= '0;
            cur_valid_q  <= 1'b0;
            prev_valid_q <= 1'b0;
        end else begin
            cur_q        <= sample_i;
            prev_q       <= cur_q;
            cur_valid_q  <= 1'b1;
            prev_valid_q <= cur_valid_q;
        end
    end

    // Raw relations only; the consumer qualifies them with prev_valid_o so a
    // cleared history register cannot fake a crossing right after reset.
    // A current sample equal to the level counts as crossed, a previous one does not.
    assign rising_o     = (prev_q < level_i) && (cur_q >= level_i);
    assign falling_o    = (prev_q > level_i) && (cur_q <= level_i);
    assign prev_valid_o = prev_valid_q;

endmodule

// File: rtl/capture_trigger_fe.sv
// rtl/capture_trigger_fe.sv - PDH sample packer, time alignment and arm/holdoff/trigger FSM
// Ports:
//   pdh_clk, rst_i          : capture clock, async active-high reset
//   samples_i               : {ch3,ch2,ch1,ch0}, one new sample set per cycle
//   arm_i                   : arm request level, rising edge arms
//   trig_mode_i             : 0 immediate, 1 rising, 2 falling, 3 either
//   trig_src_i              : channel compared against the level
//   trig_level_i            : signed trigger threshold
//   holdoff_i               : cycles during which triggers are ignored after arm
//   transaction_complete_i  : capture-finished flag from the BRAM controller
//   capture_en_o            : registered enable to the BRAM controller
//   pack_o                  : packed word to the BRAM controller, samples_i delayed 1+ALIGN_DLY
//   state_o                 : FSM state for the status register
//   trig_count_o            : saturating count of triggers fired since reset
module capture_trigger_fe
    import pdh_capture_pkg::*;
#(
    parameter int CH_W      = 16,
    parameter int ALIGN_DLY = 2,
    parameter int HO_W      = 16
) (
    input  logic                   pdh_clk,
    input  logic                   rst_i,
    input  logic [N_CH*CH_W-1:0]   samples_i,
    input  logic                   arm_i,
    input  logic [1:0]             trig_mode_i,
    input  logic [1:0]             trig_src_i,
    input  logic [CH_W-1:0]        trig_level_i,
    input  logic [HO_W-1:0]        holdoff_i,
    input  logic                   transaction_complete_i,
    output logic                   capture_en_o,
    output logic [N_CH*CH_W-1:0]   pack_o,
    output logic [2:0]             state_o,
    output logic [15:0]            trig_count_o
);

    localparam int PIPE = 1 + ALIGN_DLY;

    // ---------------- data path: free-running delay line ----------------
    // The extra ALIGN_DLY stages match the trigger path (history register plus
    // fire register) so the first word written after capture_en_o rises is the
    // sample that caused the trigger.
    logic [N_CH*CH_W-1:0] pipe_q [PIPE];

    always_ff @(posedge pdh_clk or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < PIPE; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= samples_i;
            for (int i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign pack_o = pipe_q[PIPE-1];

    // ---------------- latched configuration ----------------
    fe_state_t        state_q, state_d;
    trig_mode_t       mode_q;
    logic [1:0]       src_q;
    logic [CH_W-1:0]  level_q;
    logic [HO_W-1:0]  ho_cnt_q;

    logic             arm_edge;
    logic             arm_accept;
    logic             fire;
    logic             rising_raw, falling_raw, prev_valid;
    logic             rising, falling;
    logic             ho_last;
    logic [CH_W-1:0]  sel_sample;

    posedge_detector u_arm_edge (
        .pdh_clk (pdh_clk),
        .rst_i   (rst_i),
        .sig_i   (arm_i),
        .edge_o  (arm_edge)
    );

    assign sel_sample = samples_i[ch_lsb(src_q, CH_W) +: CH_W];

    trig_crossing_detector #(.CH_W(CH_W)) u_xing (
        .pdh_clk      (pdh_clk),
        .rst_i        (rst_i),
        .sample_i     (sel_sample),
        .level_i      (level_q),
        .rising_o     (rising_raw),
        .falling_o    (falling_raw),
        .prev_valid_o (prev_valid)
    );

    assign rising  = prev_valid & rising_raw;
    assign falling = prev_valid & falling_raw;

    // A holdoff of N keeps HOLDOFF for N cycles, with a floor of one cycle
    // for N=0, so the exit test looks at the count that is about to expire.
    assign ho_last = (ho_cnt_q <= HO_W'(1));

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d    = state_q;
        arm_accept = 1'b0;
        fire       = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (arm_edge) begin
                    arm_accept = 1'b1;
                    state_d    = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (ho_last) state_d = WAIT_TRIG;
            end
            WAIT_TRIG: begin
                case (mode_q)
                    IMMEDIATE: fire = 1'b1;
                    RISING:    fire = rising;
                    FALLING:   fire = falling;
                    default:   fire = rising | falling;
                endcase
                if (fire) state_d = WAIT_BUSY;
            end
            // A complete flag left high by the previous capture must drop
            // before the new capture's completion can be recognised.
            WAIT_BUSY: begin
                if (!transaction_complete_i) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (transaction_complete_i) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- registered state, outputs, counters ----------------
    always_ff @(posedge pdh_clk or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            capture_en_o <= 1'b0;
            trig_count_o <= '0;
            ho_cnt_q     <= '0;
            mode_q       <= IMMEDIATE;
            src_q        <= '0;
            level_q      <= '0;
        end else begin
            state_q      <= state_d;
            // Enable is high exactly while the capture is in flight, so the
            // controller sees a single rising edge per capture.
            capture_en_o <= (state_d == WAIT_BUSY) || (state_d == WAIT_DONE);
            if (fire && (trig_count_o != 16'hFFFF)) begin
                trig_count_o <= trig_count_o + 16'd1;
            end
            if (arm_accept) begin
                mode_q   <= trig_mode_t'(trig_mode_i);
                src_q    <= trig_src_i;
                level_q  <= trig_level_i;
                ho_cnt_q <= holdoff_i;
            end else if ((state_q == HOLDOFF) && (ho_cnt_q != '0)) begin
                ho_cnt_q <= ho_cnt_q - HO_W'(1);
            end
        end
    end

    assign state_o = state_q;

endmodule

// File: doc/capture_trigger_fe.md
Name: capture_trigger_fe

Overview:
Capture front end that sits directly upstream of the BRAM capture controller. It packs four 16-bit signed PDH channels into the 64-bit word that gets written to BRAM, and aligns that word in time. It also runs the arm/holdoff/trigger state machine. Its level output drives the controller's capture-enable input, and it consumes the controller's transaction-complete flag to know when a capture is finished.

Parameters:
CH_W, 16, width of one channel sample (signed)
ALIGN_DLY, 2, extra register stages on the packed data, so the first BRAM word is the trigger sample
HO_W, 16, width of the holdoff counter

Ports:
pdh_clk  in  1  capture clock
rst_i  in  1  async reset, active-high
samples_i  in  4*CH_W  {ch3,ch2,ch1,ch0}, new sample every cycle
arm_i  in  1  arm request level from the register file; rising edge detected internally
trig_mode_i  in  2  0 immediate, 1 rising, 2 falling, 3 either
trig_src_i  in  2  channel compared against the level
trig_level_i  in  CH_W  signed threshold
holdoff_i  in  HO_W  cycles during which triggers are ignored after arm
transaction_complete_i  in  1  from the BRAM controller
capture_en_o  out  1  to the BRAM controller's enable input
pack_o  out  4*CH_W  data to the BRAM controller's din
state_o  out  3  FSM state, for a status register
trig_count_o  out  16  triggers fired since reset, saturating

Behaviour:
- Reset is rst_i, asynchronous, active-high. Clock is pdh_clk.
- Values on reset:
  - capture_en_o=0, pack_o=0, state_o=IDLE, trig_count_o=0.
  - All delay stages, history registers and prev_valid cleared.
- Data path:
  - pack_o is samples_i delayed by exactly 1+ALIGN_DLY cycles; latency 3 at the defaults.
  - The data path runs continuously, independent of the FSM.
- Trigger history:
  - cur = selected channel registered once; prev = cur from the previous cycle.
  - prev_valid goes to 1 on the second cycle after reset and stays at 1.
- Crossing rules (signed comparison on the latched level):
  - rising = prev_valid & prev<level & cur>=level
  - falling = prev_valid & prev>level & cur<=level
  - either = rising | falling
  - A sample equal to the level counts as crossed; prev equal to the level is not a crossing.
- Arm edge: rising edge of arm_i, from one internal flop.
  - Accepted only in IDLE or DONE; ignored in all other states.
  - On acceptance, mode, src, level and holdoff are latched. Later changes to these inputs have no effect until the next accepted arm.
- States:
  - IDLE: wait for arm edge -> HOLDOFF.
  - HOLDOFF: counter loaded with the latched holdoff, decrements each cycle. Leave when the count is 0 -> WAIT_TRIG. With holdoff=0, HOLDOFF lasts exactly one cycle.
  - WAIT_TRIG:
    - Mode 0 fires on the first cycle.
    - Other modes fire on the crossing condition.
    - On fire: capture_en_o<=1, trig_count_o increments (saturating at 0xFFFF), then -> WAIT_BUSY.
    - Crossings during HOLDOFF are discarded; the history keeps updating.
  - WAIT_BUSY:
    - capture_en_o held at 1.
    - Wait for transaction_complete_i==0, then -> WAIT_DONE.
    - This masks a complete flag still high from the previous capture.
  - WAIT_DONE:
    - capture_en_o held at 1.
    - On transaction_complete_i==1 -> DONE, and capture_en_o<=0 on the same edge.
  - DONE: capture_en_o=0; an arm edge -> HOLDOFF.
- capture_en_o is a registered output, high from the cycle after fire until the cycle after complete is seen. The downstream controller sees exactly one rising edge per capture.
- Fire and complete in the same cycle: complete is ignored outside WAIT_BUSY and WAIT_DONE.
- An arm edge in the same cycle that DONE is entered is ignored; a new edge is needed.
- Reset mid-capture: capture_en_o drops asynchronously; the FSM returns to IDLE and the counters clear.
- state_o encoding: IDLE=0, HOLDOFF=1, WAIT_TRIG=2, WAIT_BUSY=3, WAIT_DONE=4, DONE=5. Any illegal state recovers to IDLE.

Decomposition:
- Package pdh_capture_pkg holds:
  - trig_mode_t enum (IMMEDIATE, RISING, FALLING, EITHER)
  - fe_state_t enum, with the encodings listed above
  - N_CH=4
  - the channel-slice helper function
- One sub-module: trig_crossing_detector. It takes the selected sample and the level and outputs rising, falling and prev_valid. It is combinational around two registers.
- The arm edge uses the existing posedge_detector.

Test Plan:
- Immediate mode: mode 0, holdoff 0, arm 0->1 -> capture_en_o rises 3 cycles after the arm edge (edge flop, HOLDOFF, WAIT_TRIG). Hold transaction_complete_i low for 20 cycles, then high -> capture_en_o falls the next cycle; state_o=5; trig_count_o=1.
- Rising crossing: level=100, ch1 ramps 90,95,99,100,101, src=1, mode 1 -> exactly one fire, on the sample 100. pack_o[31:16]=100 appears ALIGN_DLY+1 cycles after that sample entered samples_i.
- Holdoff: holdoff=10, ch0 crosses at cycles 3 and 15 after arm -> only the cycle-15 crossing fires; state_o=1 for 10 cycles.
- Stale complete: transaction_complete_i held at 1 before re-arm -> FSM stays in WAIT_BUSY and capture_en_o stays 1 until the flag drops, then waits for it to rise again.
- Config latch and arm ignore: change trig_level_i and pulse arm_i during WAIT_TRIG -> no state change; the original level is used.
- Reset mid-capture: assert rst_i in WAIT_DONE -> capture_en_o=0 and pack_o=0 immediately; state_o=0; trig_count_o=0.
